// File: rtl/player_sprite_engine_pkg.sv
// Shared types and constants for the VGA runner sprite path.
package runner_pkg;
  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_state_t;

  typedef logic [11:0] rgb444_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Index widths sized for the largest supported bitmap (8 frames, 32 rows, 16 cols).
  localparam int unsigned FRAME_W = 3;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned COL_W   = 4;
endpackage

// File: rtl/player_sprite_engine_if.sv
// Control, scan-position and status bundle between the game core and the player sprite engine.
interface player_sprite_engine_if;
  import runner_pkg::*;

  logic       tick;
  logic       left;
  logic       right;
  logic       jump;
  logic       pause;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       sprite_on;
  rgb444_t    rgb_sprite;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       airborne;

  modport master (
    output tick, left, right, jump, pause, pixel_x, pixel_y,
    input  sprite_on, rgb_sprite, pos_x, pos_y, airborne
  );

  modport slave (
    input  tick, left, right, jump, pause, pixel_x, pixel_y,
    output sprite_on, rgb_sprite, pos_x, pos_y, airborne
  );
endinterface

// File: rtl/player_sprite_engine_frame_rom.sv
// Runner bitmap, 8x16 texels; animation frames differ only in the leg rows 12..15.
module sprite_frame_rom
  import runner_pkg::*;
(
  input  logic [FRAME_W-1:0] frame_i,
  input  logic [ROW_W-1:0]   row_i,
  input  logic [COL_W-1:0]   col_i,
  output logic               bit_o
);
  logic [7:0] row_bits;

  // Bit 7 of each row is the leftmost texel (col 0).
  always_comb begin
    row_bits = 8'h00;
    case (row_i)
      5'd0, 5'd1, 5'd3, 5'd8, 5'd9: row_bits = 8'b0011_1100;
      5'd2:                         row_bits = 8'b0101_1000;
      5'd4:                         row_bits = 8'b0001_1000;
      5'd5:                         row_bits = 8'b0111_1110;
      5'd6, 5'd7:                   row_bits = 8'b1011_1101;
      5'd10, 5'd11:                 row_bits = 8'b0010_0100;
      5'd12: begin
        case (frame_i)
          3'd1:    row_bits = 8'b0010_0100;
          3'd2:    row_bits = 8'b0100_0100;
          default: row_bits = 8'b0110_0110;
        endcase
      end
      5'd13: begin
        case (frame_i)
          3'd1:    row_bits = 8'b0010_1000;
          3'd2:    row_bits = 8'b1000_0100;
          default: row_bits = 8'b0100_0010;
        endcase
      end
      5'd14: begin
        case (frame_i)
          3'd1:    row_bits = 8'b0011_0000;
          3'd2:    row_bits = 8'b1000_0010;
          default: row_bits = 8'b0100_0010;
        endcase
      end
      5'd15: begin
        case (frame_i)
          3'd1:    row_bits = 8'b0011_0000;
          3'd2:    row_bits = 8'b0000_0011;
          default: row_bits = 8'b1100_0011;
        endcase
      end
      default: row_bits = 8'h00;
    endcase
  end

  assign bit_o = (col_i < 4'd8) ? row_bits[3'd7 - col_i[2:0]] : 1'b0;
endmodule

// File: rtl/player_sprite_engine.sv
// Player sprite: clamped horizontal motion, gravity jump FSM, frame animation and bitmap render.
// Optional SPRITE_MIRROR_EN adds a facing register that mirrors the bitmap when running left.
module player_sprite_engine
  import runner_pkg::*;
#(
  parameter int unsigned BMP_W        = 8,
  parameter int unsigned BMP_H        = 16,
  parameter int unsigned SCALE_LOG2   = 2,
  parameter int unsigned NUM_FRAMES   = 2,
  parameter int unsigned FRAME_CYCLES = 50000000,
  parameter int unsigned MAX_X        = SCREEN_W,
  parameter int unsigned X_INIT       = 304,
  parameter int unsigned Y_GROUND     = 410,
  parameter int unsigned H_STEP       = 2,
  parameter int unsigned JUMP_V       = 12,
  parameter int unsigned GRAVITY      = 1,
  parameter rgb444_t     COLOR        = 12'h000
) (
  input logic                   clk,
  input logic                   reset_game_n,
  player_sprite_engine_if.slave bus
);
  localparam int unsigned SW    = BMP_W << SCALE_LOG2;
  localparam int unsigned SH    = BMP_H << SCALE_LOG2;
  localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [10:0] X_MAX = 11'(MAX_X - SW);

  logic [9:0]         pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [7:0]         vel_q, vel_d;
  jump_state_t        state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   anim_q, anim_d;

  logic        step, anim_wrap;
  logic [10:0] x_inc, y_fall;
  logic [8:0]  vel_inc;

  assign step      = bus.tick && !bus.pause;
  assign anim_wrap = (anim_q == CNT_W'(FRAME_CYCLES - 1));
  assign x_inc     = {1'b0, pos_x_q} + 11'(H_STEP);
  assign y_fall    = {1'b0, pos_y_q} + {3'b000, vel_q};
  assign vel_inc   = {1'b0, vel_q} + 9'(GRAVITY);

  always_ff @(posedge clk) begin
    if (!reset_game_n) begin
      pos_x_q <= 10'(X_INIT);
      pos_y_q <= 10'(Y_GROUND);
      vel_q   <= '0;
      state_q <= GROUND;
      frame_q <= '0;
      anim_q  <= '0;
    end else begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      vel_q   <= vel_d;
      state_q <= state_d;
      frame_q <= frame_d;
      anim_q  <= anim_d;
    end
  end

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vel_d   = vel_q;
    state_d = state_q;
    frame_d = frame_q;
    anim_d  = anim_q;

    if (!bus.pause) begin
      anim_d = anim_wrap ? '0 : anim_q + CNT_W'(1);
      if (anim_wrap && state_q == GROUND)
        frame_d = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
    end

    if (step) begin
      if (bus.right && !bus.left)
        pos_x_d = (x_inc > X_MAX) ? X_MAX[9:0] : x_inc[9:0];
      else if (bus.left && !bus.right)
        pos_x_d = ({1'b0, pos_x_q} < 11'(H_STEP)) ? '0 : pos_x_q - 10'(H_STEP);

      case (state_q)
        GROUND: begin
          if (bus.jump) begin
            state_d = RISE;
            vel_d   = 8'(JUMP_V);
          end
        end
        RISE: begin
          pos_y_d = pos_y_q - {2'b00, vel_q};
          // A gravity step larger than the remaining speed still ends the rise at zero.
          if (vel_q <= 8'(GRAVITY)) begin
            vel_d   = '0;
            state_d = FALL;
          end else begin
            vel_d = vel_q - 8'(GRAVITY);
          end
        end
        FALL: begin
          if (y_fall >= 11'(Y_GROUND)) begin
            pos_y_d = 10'(Y_GROUND);
            vel_d   = '0;
            state_d = GROUND;
          end else begin
            pos_y_d = y_fall[9:0];
            vel_d   = (vel_inc >= 9'(JUMP_V)) ? 8'(JUMP_V) : vel_inc[7:0];
          end
        end
        default: state_d = GROUND;
      endcase
    end

    if (state_d != GROUND)
      frame_d = '0;
  end

  logic [10:0]      dx, dy;
  logic             in_box, rom_bit;
  logic [COL_W-1:0] col, rom_col;
  logic [ROW_W-1:0] row;

  assign dx     = {1'b0, bus.pixel_x} - {1'b0, pos_x_q};
  assign dy     = {1'b0, bus.pixel_y} - {1'b0, pos_y_q};
  assign in_box = (bus.pixel_x >= pos_x_q) && (dx < 11'(SW)) &&
                  (bus.pixel_y >= pos_y_q) && (dy < 11'(SH));
  assign col    = in_box ? COL_W'(dx >> SCALE_LOG2) : '0;
  assign row    = in_box ? ROW_W'(dy >> SCALE_LOG2) : '0;

`ifdef SPRITE_MIRROR_EN
  logic facing_q, facing_d;

  always_ff @(posedge clk) begin
    if (!reset_game_n) facing_q <= 1'b0;
    else               facing_q <= facing_d;
  end

  always_comb begin
    facing_d = facing_q;
    if (step && bus.left && !bus.right)      facing_d = 1'b1;
    else if (step && bus.right && !bus.left) facing_d = 1'b0;
  end

  assign rom_col = facing_q ? (COL_W'(BMP_W - 1) - col) : col;
`else
  assign rom_col = col;
`endif

  sprite_frame_rom u_rom (
    .frame_i (frame_q),
    .row_i   (row),
    .col_i   (rom_col),
    .bit_o   (rom_bit)
  );

  assign bus.sprite_on  = in_box && rom_bit;
  assign bus.rgb_sprite = COLOR;
  assign bus.pos_x      = pos_x_q;
  assign bus.pos_y      = pos_y_q;
  assign bus.airborne   = (state_q != GROUND);
endmodule

// File: tb/tb_player_sprite_engine.sv
// Scoreboard bench for player_sprite_engine (FRAME_CYCLES=10, NUM_FRAMES=3); SPRITE_MIRROR_EN aware.
module tb_player_sprite_engine;
  import runner_pkg::*;

  logic clk = 1'b0;
  logic reset_game_n = 1'b0;
  always #5 clk = ~clk;

  player_sprite_engine_if ifc();

  player_sprite_engine #(
    .NUM_FRAMES   (3),
    .FRAME_CYCLES (10)
  ) dut (
    .clk          (clk),
    .reset_game_n (reset_game_n),
    .bus          (ifc.slave)
  );

`ifdef SPRITE_MIRROR_EN
  localparam logic MIRROR = 1'b1;
`else
  localparam logic MIRROR = 1'b0;
`endif

  typedef struct {
    int    due;
    bit    is_pix;
    int    x;
    int    y;
    logic  air;
    logic  pix;
    string name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   keff = 0;
  int   checks = 0;
  int   errors = 0;
  bit   tb_done = 1'b0;

  // Column of row 13 that is opaque for frames 0,1,2 (hand-read from the bitmap).
  int hit[3] = '{1, 2, 0};
  // Expected pos_y after each tick of a single jump from the ground.
  int jy[26] = '{410, 398, 387, 377, 368, 360, 353, 347, 342, 338, 335, 333, 332,
                 332, 333, 335, 338, 342, 347, 353, 360, 368, 377, 387, 398, 410};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cycle();
    @(posedge clk);
    if (!reset_game_n)   keff = 0;
    else if (!ifc.pause) keff++;
    #1;
  endtask

  task automatic idle();
    ifc.tick = 1'b0; ifc.left = 1'b0; ifc.right = 1'b0;
    ifc.jump = 1'b0; ifc.pause = 1'b0;
  endtask

  task automatic exp_pos(input string nm, input int x, input int y, input logic air);
    exp_t e;
    e.due = cyc + 1; e.is_pix = 1'b0; e.x = x; e.y = y; e.air = air; e.pix = 1'b0; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic exp_pix(input string nm, input int px, input int py, input logic v);
    exp_t e;
    ifc.pixel_x = 10'(px);
    ifc.pixel_y = 10'(py);
    e.due = cyc; e.is_pix = 1'b1; e.x = px; e.y = py; e.air = 1'b0; e.pix = v; e.name = nm;
    sbq.push_back(e);
  endtask

  // Monitor: compares every expectation that has come due at this falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        checks++;
        if (e.is_pix) begin
          if (ifc.sprite_on !== e.pix) begin
            errors++;
            $display("FAIL %s: sprite_on at (%0d,%0d) got %b want %b", e.name, e.x, e.y, ifc.sprite_on, e.pix);
          end else
            $display("chk %0d %s pix (%0d,%0d)=%b", checks, e.name, e.x, e.y, e.pix);
        end else begin
          if (ifc.pos_x !== 10'(e.x) || ifc.pos_y !== 10'(e.y) || ifc.airborne !== e.air ||
              ifc.rgb_sprite !== 12'h000) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d air=%b rgb=%h want x=%0d y=%0d air=%b rgb=000",
                     e.name, ifc.pos_x, ifc.pos_y, ifc.airborne, ifc.rgb_sprite, e.x, e.y, e.air);
          end else
            $display("chk %0d %s x=%0d y=%0d air=%b", checks, e.name, e.x, e.y, e.air);
        end
      end
      if (tb_done) begin
        checks++;
        if (sbq.size() != 0) begin
          errors++;
          $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    ifc.pixel_x = '0;
    ifc.pixel_y = '0;
    reset_game_n = 1'b0;
    repeat (3) cycle();
    exp_pos("reset", 304, 410, 1'b0);
    cycle();
    reset_game_n = 1'b1;

    // Grounded animation: frames 0,1,2,0,1 every 10 clocks, probed on row 13.
    for (int i = 0; i < 45; i++) begin
      cycle();
      exp_pix("anim", 304 + (i % 3) * 4 + 1, 410 + 54, hit[(keff / 10) % 3] == (i % 3));
    end

    // Single jump: full trajectory, frame forced to 0 while airborne.
    for (int j = 0; j < 26; j++) begin
      cycle();
      if (j == 0) exp_pix("pre_jump", 309, 464, hit[(keff / 10) % 3] == 1);
      else        exp_pix("air_frame", 309, jy[j - 1] + 54, 1'b1);
      ifc.tick = 1'b1;
      ifc.jump = (j == 0);
      exp_pos("jump", 304, jy[j], j != 25);
    end
    cycle();
    idle();

    // Second jump with a 100-tick pause after the fourth rise tick.
    for (int j = 0; j < 26; j++) begin
      if (j == 5) begin
        for (int p = 0; p < 100; p++) begin
          cycle();
          ifc.tick = 1'b1; ifc.pause = 1'b1; ifc.jump = (p % 7 == 0);
          exp_pos("pause_hold", 304, jy[4], 1'b1);
        end
        cycle();
        idle();
      end
      cycle();
      ifc.tick = 1'b1;
      ifc.jump = (j == 0);
      exp_pos("resume", 304, jy[j], j != 25);
    end
    cycle();
    idle();

    // Jump while drifting right, then reset mid-air with inputs still active.
    for (int j = 0; j < 4; j++) begin
      cycle();
      ifc.tick = 1'b1; ifc.jump = (j == 0); ifc.right = 1'b1;
      exp_pos("drift", 304 + 2 * (j + 1), jy[j], 1'b1);
    end
    cycle();
    ifc.jump = 1'b1;
    reset_game_n = 1'b0;
    exp_pos("mid_reset", 304, 410, 1'b0);
    cycle();
    idle();
    reset_game_n = 1'b1;

    // Animation from reset with a 30-clock pause that must freeze the frame counter.
    for (int i = 0; i < 60; i++) begin
      cycle();
      ifc.pause = (i >= 12 && i < 42);
      exp_pix("anim_pause", 304 + (i % 3) * 4 + 1, 464, hit[(keff / 10) % 3] == (i % 3));
    end
    cycle();
    idle();

    // Horizontal clamps at both screen edges.
    for (int i = 1; i <= 200; i++) begin
      cycle();
      ifc.tick = 1'b1; ifc.right = 1'b1; ifc.left = 1'b0;
      exp_pos("right_clamp", (304 + 2 * i > 608) ? 608 : 304 + 2 * i, 410, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      ifc.tick = 1'b1; ifc.right = 1'b1; ifc.left = 1'b1;
      exp_pos("both_hold", 608, 410, 1'b0);
    end
    for (int i = 1; i <= 310; i++) begin
      cycle();
      ifc.tick = 1'b1; ifc.right = 1'b0; ifc.left = 1'b1;
      exp_pos("left_clamp", (608 - 2 * i < 0) ? 0 : 608 - 2 * i, 410, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      ifc.tick = 1'b1; ifc.right = 1'b0; ifc.left = 1'b0;
      exp_pos("none_hold", 0, 410, 1'b0);
    end

    // Render boxes and mirroring at the reset position.
    cycle();
    idle();
    reset_game_n = 1'b0;
    exp_pos("reset2", 304, 410, 1'b0);
    cycle();
    reset_game_n = 1'b1;
    cycle(); exp_pix("box_left_in",   304, 434, 1'b1);
    cycle(); exp_pix("box_left_out",  303, 434, 1'b0);
    cycle(); exp_pix("box_right_in",  335, 434, 1'b1);
    cycle(); exp_pix("box_right_out", 336, 434, 1'b0);
    cycle(); exp_pix("box_top_out",   304, 409, 1'b0);
    cycle(); exp_pix("box_bot_in",    304, 473, 1'b1);
    cycle(); exp_pix("box_bot_out",   304, 474, 1'b0);
    cycle(); exp_pix("row2_col1",     309, 419, 1'b1);
    cycle();
    ifc.tick = 1'b1; ifc.left = 1'b1;
    exp_pos("step_left", 302, 410, 1'b0);
    cycle();
    idle();
    exp_pix("facing_left", 307, 419, !MIRROR);
    cycle();
    ifc.tick = 1'b1; ifc.right = 1'b1;
    exp_pos("step_right", 304, 410, 1'b0);
    cycle();
    idle();
    exp_pix("facing_right", 309, 419, 1'b1);

    repeat (3) cycle();
    tb_done = 1'b1;
  end
endmodule
